// File: rtl/bus_cycle_ctrl.sv
// 8085 multiplexed-bus cycle controller.
// Runs one T1/T2/TW/T3 machine cycle per accepted request.
module bus_cycle_ctrl #(
    parameter int WAIT_W     = 4,
    parameter int WAIT_LIMIT = 0
) (
    input  logic        phi1,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  cyc_type,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        ready,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  a_hi,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        INTAn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    output logic [7:0]  rdata,
    output logic        done,
    output logic        timeout,
    output logic        busy,
    output logic [4:0]  t_state
);

    typedef enum logic [4:0] {
        TI = 5'b00001,
        TW = 5'b00010,
        T3 = 5'b00100,
        T2 = 5'b01000,
        T1 = 5'b10000
    } state_t;

    localparam logic [2:0] C_OF   = 3'd0;
    localparam logic [2:0] C_MR   = 3'd1;
    localparam logic [2:0] C_MW   = 3'd2;
    localparam logic [2:0] C_IOR  = 3'd3;
    localparam logic [2:0] C_IOW  = 3'd4;
    localparam logic [2:0] C_INTA = 3'd5;

    localparam logic [WAIT_W-1:0] LIM  = WAIT_W'(WAIT_LIMIT);
    localparam logic [WAIT_W-1:0] WMAX = '1;

    state_t            state;
    logic [2:0]        typ;
    logic [7:0]        wd_q;
    logic [WAIT_W-1:0] wcnt;
    logic              armed;

    logic take;
    logic rd_c;
    logic wr_c;
    logic ia_c;
    logic io_new;

    // Only TI and T3 may accept; reserved codes are simply dropped.
    assign take = start && (state == TI || state == T3)
                  && (cyc_type <= C_INTA);

    assign rd_c   = (typ == C_OF) || (typ == C_MR) || (typ == C_IOR);
    assign wr_c   = (typ == C_MW) || (typ == C_IOW);
    assign ia_c   = (typ == C_INTA);
    assign io_new = (cyc_type == C_IOR) || (cyc_type == C_IOW);

    assign t_state = state;

    // {S1, S0, IOMn}
    function automatic logic [2:0] status(input logic [2:0] t);
        case (t)
            C_OF:    status = 3'b110;
            C_MR:    status = 3'b100;
            C_MW:    status = 3'b010;
            C_IOR:   status = 3'b101;
            C_IOW:   status = 3'b011;
            C_INTA:  status = 3'b111;
            default: status = 3'b000;
        endcase
    endfunction

    always_ff @(posedge phi1) begin
        if (reset) begin
            state   <= TI;
            typ     <= C_OF;
            wd_q    <= 8'h00;
            wcnt    <= '0;
            armed   <= 1'b0;
            ALE     <= 1'b0;
            RDn     <= 1'b1;
            WRn     <= 1'b1;
            INTAn   <= 1'b1;
            IOMn    <= 1'b0;
            S1      <= 1'b0;
            S0      <= 1'b0;
            ad_oe   <= 1'b0;
            ad_out  <= 8'h00;
            a_hi    <= 8'h00;
            rdata   <= 8'h00;
            done    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                TI: ;
                T1: begin
                    state <= T2;
                    ALE   <= 1'b0;
                    RDn   <= ~rd_c;
                    WRn   <= ~wr_c;
                    INTAn <= ~ia_c;
                    ad_oe <= wr_c;
                    if (wr_c) ad_out <= wd_q;
                end
                T2: begin
                    if (ready) begin
                        state <= T3;
                    end else begin
                        state <= TW;
                        wcnt  <= WAIT_W'(1);
                    end
                end
                TW: begin
                    if (ready) begin
                        state <= T3;
                    end else if (WAIT_LIMIT != 0 && wcnt == LIM) begin
                        state <= T3;
                        armed <= 1'b1;
                    end else if (wcnt != WMAX) begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                T3: begin
                    done    <= 1'b1;
                    timeout <= armed;
                    armed   <= 1'b0;
                    wcnt    <= '0;
                    if (rd_c || ia_c) rdata <= ad_in;
                    state   <= TI;
                    busy    <= 1'b0;
                    RDn     <= 1'b1;
                    WRn     <= 1'b1;
                    INTAn   <= 1'b1;
                    ad_oe   <= 1'b0;
                end
                default: state <= TI;
            endcase
            // A new request overrides the T3 wind-down above.
            if (take) begin
                typ            <= cyc_type;
                wd_q           <= wdata;
                state          <= T1;
                busy           <= 1'b1;
                ALE            <= 1'b1;
                RDn            <= 1'b1;
                WRn            <= 1'b1;
                INTAn          <= 1'b1;
                ad_oe          <= 1'b1;
                ad_out         <= addr[7:0];
                a_hi           <= io_new ? addr[7:0] : addr[15:8];
                {S1, S0, IOMn} <= status(cyc_type);
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized bench for bus_cycle_ctrl against a per-transaction
// phase model.
module tb_bus_cycle_ctrl;

    localparam int LIM = 3;

    logic        phi1 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  cyc_type = 3'd0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  wdata = 8'h0;
    logic        ready = 1'b1;
    logic [7:0]  ad_in = 8'h0;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  a_hi;
    logic        ALE;
    logic        RDn;
    logic        WRn;
    logic        INTAn;
    logic        IOMn;
    logic        S1;
    logic        S0;
    logic [7:0]  rdata;
    logic        done;
    logic        timeout;
    logic        busy;
    logic [4:0]  t_state;

    bus_cycle_ctrl #(
        .WAIT_W    (4),
        .WAIT_LIMIT(LIM)
    ) dut (
        .phi1    (phi1),
        .reset   (reset),
        .start   (start),
        .cyc_type(cyc_type),
        .addr    (addr),
        .wdata   (wdata),
        .ready   (ready),
        .ad_in   (ad_in),
        .ad_out  (ad_out),
        .ad_oe   (ad_oe),
        .a_hi    (a_hi),
        .ALE     (ALE),
        .RDn     (RDn),
        .WRn     (WRn),
        .INTAn   (INTAn),
        .IOMn    (IOMn),
        .S1      (S1),
        .S0      (S0),
        .rdata   (rdata),
        .done    (done),
        .timeout (timeout),
        .busy    (busy),
        .t_state (t_state)
    );

    always #5 phi1 = ~phi1;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] a;
        logic [7:0]  d;
        int          w;
        logic [7:0]  rv;
        bit          chain;
    } txn_t;

    int     n_chk = 0;
    int     n_err = 0;
    txn_t   q[$];
    logic [7:0] exp_rd;
    bit     prev_to;
    bit     chained;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge phi1);
        #1;
    endtask

    function automatic txn_t mk(input logic [2:0] t, input logic [15:0] a,
                                input logic [7:0] d, input int w,
                                input logic [7:0] rv, input bit chain);
        txn_t x;
        x.t = t; x.a = a; x.d = d; x.w = w; x.rv = rv; x.chain = chain;
        return x;
    endfunction

    // {S1, S0, IOMn} by cycle type
    function automatic logic [2:0] stat(input logic [2:0] t);
        case (t)
            3'd0:    return 3'b110;
            3'd1:    return 3'b100;
            3'd2:    return 3'b010;
            3'd3:    return 3'b101;
            3'd4:    return 3'b011;
            3'd5:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    task automatic drive_req(input txn_t x);
        start    = 1'b1;
        cyc_type = x.t;
        addr     = x.a;
        wdata    = x.d;
    endtask

    // ph: 0=T1 1=T2 2=TW 3=T3
    task automatic chk_phase(input txn_t x, input int ph);
        logic rd, wr, ia, io;
        logic [4:0] ts;
        logic [7:0] ahi;
        rd  = (x.t == 3'd0) || (x.t == 3'd1) || (x.t == 3'd3);
        wr  = (x.t == 3'd2) || (x.t == 3'd4);
        ia  = (x.t == 3'd5);
        io  = (x.t == 3'd3) || (x.t == 3'd4);
        ts  = (ph == 0) ? 5'b10000 : (ph == 1) ? 5'b01000 :
              (ph == 2) ? 5'b00010 : 5'b00100;
        ahi = io ? x.a[7:0] : x.a[15:8];
        chk("tstate", t_state, ts);
        chk("status", {S1, S0, IOMn}, stat(x.t));
        chk("a_hi", a_hi, ahi);
        chk("busy", busy, 1);
        if (ph == 0) begin
            chk("t1ctl", {ALE, RDn, WRn, INTAn, ad_oe}, 5'b11111);
            chk("t1ad", ad_out, x.a[7:0]);
        end else begin
            chk("strobe", {ALE, RDn, WRn, INTAn, ad_oe},
                {1'b0, ~rd, ~wr, ~ia, wr});
            if (wr) chk("wdata", ad_out, x.d);
        end
    endtask

    initial begin
        txn_t x;
        int   n;
        q.push_back(mk(3'd0, 16'h1234, 8'h00, 0, 8'h7E, 1'b0));
        q.push_back(mk(3'd2, 16'h8000, 8'hA5, 2, 8'h00, 1'b0));
        q.push_back(mk(3'd3, 16'h0042, 8'h11, 0, 8'h5C, 1'b0));
        q.push_back(mk(3'd5, 16'h0000, 8'h00, 1, 8'hC7, 1'b0));
        q.push_back(mk(3'd2, 16'hBEEF, 8'h3C, 6, 8'h00, 1'b0));
        q.push_back(mk(3'd1, 16'h4000, 8'h00, 9, 8'h6D, 1'b0));
        q.push_back(mk(3'd1, 16'h2000, 8'h00, 0, 8'h99, 1'b1));
        q.push_back(mk(3'd1, 16'h2001, 8'h00, 0, 8'h98, 1'b0));
        repeat (40) begin
            q.push_back(mk(3'($urandom_range(0, 5)), 16'($urandom),
                           8'($urandom), $urandom_range(0, 5),
                           8'($urandom), $urandom_range(0, 2) == 0));
        end
        q[q.size()-1].chain = 1'b0;

        reset = 1'b1;
        tick;
        tick;
        chk("rst_ts", t_state, 5'b00001);
        chk("rst_ctl",
            {ALE, RDn, WRn, INTAn, IOMn, S1, S0, ad_oe, busy, done, timeout},
            11'b01110000000);
        chk("rst_ad", {ad_out, a_hi, rdata}, 24'h0);
        reset   = 1'b0;
        exp_rd  = 8'h00;
        chained = 1'b0;
        prev_to = 1'b0;

        foreach (q[i]) begin
            x = q[i];
            if (!chained) begin
                if ($urandom_range(0, 3) == 0) begin
                    start    = 1'b1;
                    cyc_type = 3'(6 + $urandom_range(0, 1));
                    tick;
                    chk("rsvd_ts", t_state, 5'b00001);
                    chk("rsvd_busy", {busy, done}, 0);
                    start = 1'b0;
                end
                drive_req(x);
                ready = 1'b1;
                tick;
                chk("t1_nodone", {done, timeout}, 0);
            end else begin
                chk("b2b_done", {done, timeout}, {1'b1, prev_to});
                chk("b2b_rdata", rdata, exp_rd);
            end
            n = (x.w < LIM) ? x.w : LIM;
            for (int j = 0; j < 3 + n; j++) begin
                chk_phase(x, (j == 0) ? 0 : (j == 1) ? 1 :
                             (j == 2 + n) ? 3 : 2);
                if (j > 0) chk("nodone", done, 0);
                ready = (j >= 1 && j <= x.w) ? 1'b0 : 1'b1;
                ad_in = (j == 2 + n) ? x.rv : 8'($urandom);
                if (j == 2 + n) begin
                    if (x.chain) drive_req(q[i+1]);
                    else start = 1'b0;
                end else begin
                    start    = 1'($urandom_range(0, 1));
                    cyc_type = 3'($urandom_range(0, 5));
                    addr     = 16'($urandom);
                    wdata    = 8'($urandom);
                end
                tick;
            end
            if (x.t != 3'd2 && x.t != 3'd4) exp_rd = x.rv;
            prev_to = (x.w > LIM);
            chained = x.chain;
            if (!chained) begin
                chk("done", {done, timeout}, {1'b1, prev_to});
                chk("rdata", rdata, exp_rd);
                chk("idle", {t_state, busy, RDn, WRn, INTAn, ad_oe},
                    {5'b00001, 1'b0, 4'b1110});
                chk("idle_stat", {S1, S0, IOMn}, stat(x.t));
                start = 1'b0;
                ready = 1'b1;
            end
        end

        tick;
        chk("done_clr", {done, timeout}, 0);

        // Reset in the middle of a waited write.
        drive_req(mk(3'd2, 16'h4321, 8'h5A, 0, 8'h00, 1'b0));
        tick;
        start = 1'b0;
        ready = 1'b0;
        tick;
        tick;
        chk("mid_tw", {t_state, WRn}, {5'b00010, 1'b0});
        reset = 1'b1;
        tick;
        chk("abort_ts", t_state, 5'b00001);
        chk("abort_ctl", {WRn, ad_oe, done, busy}, 4'b1000);
        chk("abort_rd", rdata, 8'h00);
        reset = 1'b0;
        ready = 1'b1;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
- Drives the external 8085 multiplexed bus for one machine cycle per request: opcode fetch, memory read/write, I/O read/write or interrupt acknowledge.
- Sequences the T1/T2/TW/T3 states, inserts wait states from READY, and returns fetched bytes.
- The fetched opcode byte feeds the instruction decoder as next_instruction. The decoder's M-cycle sequencer issues the requests; its internal T4–T6 states are not this block's concern.

Parameters:
- WAIT_W, 4, width of wait-state counter.
- WAIT_LIMIT, 0, max TW states before forced completion; 0 = unlimited; must be < 2^WAIT_W.

Ports:
- phi1  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request strobe, sampled on phi1 edge.
- cyc_type  in  3  000 opcode fetch, 001 mem read, 010 mem write, 011 IO read, 100 IO write, 101 INTA, 110/111 reserved.
- addr  in  16  cycle address.
- wdata  in  8  write data.
- ready  in  1  external READY pin.
- ad_in  in  8  AD7–AD0 input path.
- ad_out  out  8  AD7–AD0 drive value.
- ad_oe  out  1  AD bus output enable.
- a_hi  out  8  A15–A8.
- ALE  out  1  address latch enable.
- RDn, WRn, INTAn  out  1  active-low strobes.
- IOMn, S1, S0  out  1  status lines.
- rdata  out  8  last captured read byte.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  pulses with done when WAIT_LIMIT forced completion.
- busy  out  1  high in T1/T2/TW/T3.
- t_state  out  5  one-hot {T1,T2,T3,TW,TI}.

Behaviour:
- Reset (synchronous): state TI, ALE=0, RDn=WRn=INTAn=1, IOMn=0, S1S0=00, ad_oe=0, ad_out=00, a_hi=00, rdata=00, done=0, timeout=0, busy=0, wait count=0. Reset mid-cycle aborts immediately: strobes deassert on the next edge, no done, rdata unchanged from its previous value only if not reset (reset clears it).
- Acceptance: start accepted only in TI or T3. On acceptance, cyc_type, addr and wdata are latched and the next state is T1. start in T1/T2/TW is ignored (no queueing). Reserved cyc_type is ignored (state unchanged; request dropped).
- Outputs are Moore: a function of the current state plus latched request only.
- Status per latched type (held from T1 through T3; S1S0/IOMn keep their last values in TI):
  - OF: S1S0=11, IOMn=0.
  - MR: 10/0.
  - MW: 01/0.
  - IOR: 10/1.
  - IOW: 01/1.
  - INTA: 11/1.
- T1: ALE=1, ad_oe=1, ad_out=addr[7:0]. a_hi=addr[15:8], except IO cycles where a_hi=addr[7:0]. Next state T2. a_hi is held through T3.
- T2: ALE=0.
  - Reads (OF/MR/IOR): RDn=0, ad_oe=0.
  - INTA: INTAn=0, ad_oe=0.
  - Writes: WRn=0, ad_oe=1, ad_out=wdata.
  - ready=1 at the end of T2 gives T3; otherwise TW with wait count=1.
- TW: strobes and ad drive as in T2. ready=1 gives T3. If WAIT_LIMIT≠0 and wait count==WAIT_LIMIT, T3 is forced and the timeout flag is armed. Otherwise count++ (saturating).
- T3: strobes and drive as in T2. At the edge leaving T3:
  - Read/INTA: rdata<=ad_in.
  - done=1 and timeout=armed flag for exactly the following cycle; flag and count cleared.
  - Next state is T1 if start is accepted, else TI.
- Back-to-back requests: start high during T3 gives T1 immediately. Strobes go high in that T1, because T1 never asserts RD/WR/INTA.
- Latency with no waits: request edge to done = 4 cycles (T1, T2, T3, then done cycle).
- Never RDn=0 and WRn=0 together. INTAn and RDn are mutually exclusive. ad_oe=0 whenever RDn=0 or INTAn=0.

Test Plan:
- OF addr=1234h, ready=1, ad_in=7Eh in T3 -> T1: ALE=1, ad_out=34h, a_hi=12h, S1S0=11, IOMn=0; T2–T3: RDn=0, ad_oe=0; rdata=7Eh, done pulses 4 cycles after request.
- MW addr=8000h, wdata=A5h, ready low for 2 cycles -> two TW states; WRn=0 and ad_out=A5h through T2, TW, TW, T3; S1S0=01; done after 6 cycles; timeout=0.
- IOR addr=0042h -> a_hi=42h, ad_out=42h in T1, IOMn=1, S1S0=10; INTA cycle -> INTAn=0 and RDn=1 throughout.
- WAIT_LIMIT=3, ready held 0 -> exactly 3 TW then T3; done=1 with timeout=1; next cycle both 0.
- MR then MR issued in T3 -> second T1 follows T3 with no TI; t_state sequence T1,T2,T3,T1,T2,T3,TI.
- reset asserted in TW of a write -> next cycle TI, WRn=1, ad_oe=0, done=0, rdata=00; start during T2 and cyc_type=111 in TI both ignored.
